fp_align_arbiter: RTL
=====================

// Module: fp_align_arbiter
// PURPOSE
//  Shares one extract/align FP datapath (product-plus-addend align, add/sub front end)
//  between two requesters: port 0 = FADD/FSUB, port 1 = R4 fused ops (FMADD/FMSUB/FNMADD/FNMSUB).
//  Arbitrates per cycle, registers the winning operands onto the datapath inputs and
//  tracks each issued op through the fixed-latency datapath. Returns each result to its
//  owner with the owner's tag. Sits between FP issue and the shared align/add/normalize pipe.
// PARAMETERS
//  LAT      2   cycles from dp_valid high to matching dp_res_data valid (legal 1..8)
//  TAG_W    5   requester tag width (ROB/scoreboard id)
//  RES_W    32  datapath result width
//  MAX_WAIT 4   max consecutive cycles port 0 may lose before it is forced to win (>=1)
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous reset, active-high
//  flush        in   1      kill all queued and in-flight ops
//  reqN_valid   in   1      N=0,1: request valid (must not depend on reqN_ready)
//  reqN_ready   out  1      N=0,1: grant; transfer when valid&ready
//  reqN_tag     in   TAG_W  N=0,1: request tag
//  reqN_exp1    in   8      N=0,1: operand-1 exponent
//  reqN_mant1   in   47     N=0,1: operand-1 mantissa (product width)
//  reqN_sign1   in   1      N=0,1: operand-1 sign
//  reqN_num2    in   32     N=0,1: operand-2 IEEE-754 single
//  reqN_add_sub in   1      N=0,1: 1 = negate operand 2
//  reqN_nan1    in   1      N=0,1: operand-1 is NaN
//  reqN_zero1   in   1      N=0,1: operand-1 is zero
//  dp_valid     out  1      datapath input valid
//  dp_exp1/dp_mant1/dp_sign1/dp_num2/dp_add_sub/dp_nan1/dp_zero1  out  8/47/1/32/1/1/1  registered operands
//  dp_res_data  in   RES_W  datapath result, valid LAT cycles after dp_valid
//  rspN_valid   out  1      N=0,1: result for port N (no back-pressure; owner must accept)
//  rsp_tag      out  TAG_W  tag of the current response
//  rsp_data     out  RES_W  dp_res_data pass-through
//  busy         out  1      any op issued or in flight
// BEHAVIOUR
//  - Reset: dp_valid=0, all dp_* operand regs=0, rsp0/1_valid=0, rsp_tag=0, busy=0,
//    wait counter=0, tracker empty.
//  - Ready is combinational: at most one of req0_ready/req1_ready high per cycle. Both low
//    while flush=1. Ready for a port is never asserted unless that port is valid.
//  - Arbitration: port 1 wins by default. Port 0 wins if only port 0 is valid, or if
//    wait_cnt==MAX_WAIT.
//  - wait_cnt: width $clog2(MAX_WAIT+1). Increments (saturating at MAX_WAIT) when
//    req0_valid & !req0_ready. Clears when port 0 is granted or req0_valid=0.
//  - Issue: on grant, the operands are captured into dp_* regs at the next clk edge and
//    dp_valid=1 for exactly that cycle. Throughput is one op per cycle. With no grant,
//    dp_valid=0 and operand regs hold their values.
//  - Tracker: LAT-deep shift register of {valid, owner, tag}. Entry 0 loads from the
//    dp_valid cycle. On the cycle the LAT-th entry is valid, rsp<owner>_valid=1 and
//    rsp_tag=entry tag; rsp_data = dp_res_data (combinational). Results return in issue
//    order, at most one per cycle. rsp0_valid & rsp1_valid are never both high.
//  - flush: same cycle, tracker valids and dp_valid clear and the response of that cycle
//    is suppressed. wait_cnt clears. No grant occurs during the flush cycle.
//    A request dropped by flush is the requester's responsibility.
//  - busy = dp_valid | any tracker valid.
//  - Reset mid-operation: every in-flight op is lost and no response is produced.
// CONFIGURATION
//  FP_ALIGN_ARB_RR_EN defined: port 1 priority and wait_cnt are replaced by a 1-bit
//    round-robin pointer (reset 0 = port 0 preferred). When both ports are valid, the
//    preferred port wins and the pointer flips to the other port. A single valid
//    requester wins and the pointer does not change. MAX_WAIT is unused.
//  Undefined: fixed priority plus the starvation counter, as above.
// TESTING
//  - Lone req0, tag=3, LAT=2: req0_ready same cycle, dp_valid next cycle,
//    rsp0_valid with rsp_tag=3 exactly 3 cycles after the grant edge.
//  - Both valid every cycle, MAX_WAIT=4: grant pattern 1,1,1,1,0 repeating;
//    wait_cnt never exceeds 4.
//  - Back-to-back req1 tags 0..7: dp_valid high 8 consecutive cycles; rsp1 tags 0..7
//    in order, no gaps.
//  - flush asserted with 2 ops in flight: no rspN_valid afterwards, busy=0 next cycle,
//    ready low during the flush cycle.
//  - Reset asserted asynchronously mid-stream: all outputs 0 immediately; the first
//    grant after release responds normally.
//  - FP_ALIGN_ARB_RR_EN, both valid: grants alternate 0,1,0,1; lone req1 leaves the
//    pointer unchanged.

Source files
------------

// File: rtl/fp_align_arbiter.sv
// Two-port arbiter feeding one shared fixed-latency FP extract/align datapath; returns results tagged to their owner.
// Build option: define FP_ALIGN_ARB_RR_EN for round-robin arbitration instead of port-1 priority with a starvation guard.
module fp_align_arbiter #(
   parameter int LAT      = 2,
   parameter int TAG_W    = 5,
   parameter int RES_W    = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic [7:0]       req0_exp1,
   input  logic [46:0]      req0_mant1,
   input  logic             req0_sign1,
   input  logic [31:0]      req0_num2,
   input  logic             req0_add_sub,
   input  logic             req0_nan1,
   input  logic             req0_zero1,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [TAG_W-1:0] req1_tag,
   input  logic [7:0]       req1_exp1,
   input  logic [46:0]      req1_mant1,
   input  logic             req1_sign1,
   input  logic [31:0]      req1_num2,
   input  logic             req1_add_sub,
   input  logic             req1_nan1,
   input  logic             req1_zero1,
   output logic             dp_valid,
   output logic [7:0]       dp_exp1,
   output logic [46:0]      dp_mant1,
   output logic             dp_sign1,
   output logic [31:0]      dp_num2,
   output logic             dp_add_sub,
   output logic             dp_nan1,
   output logic             dp_zero1,
   input  logic [RES_W-1:0] dp_res_data,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [RES_W-1:0] rsp_data,
   output logic             busy
);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [7:0]       exp1;
      logic [46:0]      mant1;
      logic             sign1;
      logic [31:0]      num2;
      logic             add_sub;
      logic             nan1;
      logic             zero1;
   } op_t;

   op_t  req0_op;
   op_t  req1_op;
   op_t  op_d;
   op_t  op_q;
   logic grant0;
   logic grant1;
   logic dp_valid_d;
   logic dp_valid_q;
   logic dp_owner_d;
   logic dp_owner_q;

   logic [LAT-1:0]            trk_vld_d;
   logic [LAT-1:0]            trk_vld_q;
   logic [LAT-1:0]            trk_own_d;
   logic [LAT-1:0]            trk_own_q;
   logic [LAT-1:0][TAG_W-1:0] trk_tag_d;
   logic [LAT-1:0][TAG_W-1:0] trk_tag_q;
   logic                      rsp_fire;

   always_comb begin
      req0_op         = '0;
      req0_op.tag     = req0_tag;
      req0_op.exp1    = req0_exp1;
      req0_op.mant1   = req0_mant1;
      req0_op.sign1   = req0_sign1;
      req0_op.num2    = req0_num2;
      req0_op.add_sub = req0_add_sub;
      req0_op.nan1    = req0_nan1;
      req0_op.zero1   = req0_zero1;
      req1_op         = '0;
      req1_op.tag     = req1_tag;
      req1_op.exp1    = req1_exp1;
      req1_op.mant1   = req1_mant1;
      req1_op.sign1   = req1_sign1;
      req1_op.num2    = req1_num2;
      req1_op.add_sub = req1_add_sub;
      req1_op.nan1    = req1_nan1;
      req1_op.zero1   = req1_zero1;
   end

`ifdef FP_ALIGN_ARB_RR_EN
   // rr_ptr_q names the port that wins the next contested cycle.
   logic rr_ptr_d;
   logic rr_ptr_q;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!flush && !reset) begin
         if (req0_valid && req1_valid) begin
            grant0 = ~rr_ptr_q;
            grant1 = rr_ptr_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant0 && req1_valid) rr_ptr_d = 1'b1;
      if (grant1 && req0_valid) rr_ptr_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_ptr_q <= 1'b0;
      else       rr_ptr_q <= rr_ptr_d;
   end
`else
   localparam int WC_W = $clog2(MAX_WAIT + 1);

   // Port 1 normally wins; port 0 is forced through after MAX_WAIT consecutive losses.
   logic [WC_W-1:0] wait_cnt_d;
   logic [WC_W-1:0] wait_cnt_q;
   logic            starved;

   assign starved = (wait_cnt_q == WC_W'(MAX_WAIT));

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!flush && !reset) begin
         if (req0_valid && (!req1_valid || starved)) grant0 = 1'b1;
         else if (req1_valid)                        grant1 = 1'b1;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (flush || !req0_valid || grant0) wait_cnt_d = '0;
      else if (!starved)                  wait_cnt_d = wait_cnt_q + WC_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) wait_cnt_q <= '0;
      else       wait_cnt_q <= wait_cnt_d;
   end
`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      dp_valid_d = grant0 | grant1;
      dp_owner_d = dp_owner_q;
      op_d       = op_q;
      if (grant0) begin
         op_d       = req0_op;
         dp_owner_d = 1'b0;
      end else if (grant1) begin
         op_d       = req1_op;
         dp_owner_d = 1'b1;
      end
   end

   // Tracker mirrors the datapath: entry LAT-1 lines up with dp_res_data.
   always_comb begin
      trk_vld_d    = '0;
      trk_own_d    = trk_own_q;
      trk_tag_d    = trk_tag_q;
      trk_own_d[0] = dp_owner_q;
      trk_tag_d[0] = op_q.tag;
      for (int i = 1; i < LAT; i++) begin
         trk_own_d[i] = trk_own_q[i-1];
         trk_tag_d[i] = trk_tag_q[i-1];
      end
      if (!flush) begin
         trk_vld_d[0] = dp_valid_q;
         for (int i = 1; i < LAT; i++) trk_vld_d[i] = trk_vld_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dp_valid_q <= 1'b0;
         dp_owner_q <= 1'b0;
         op_q       <= '0;
         trk_vld_q  <= '0;
         trk_own_q  <= '0;
         trk_tag_q  <= '0;
      end else begin
         dp_valid_q <= dp_valid_d;
         dp_owner_q <= dp_owner_d;
         op_q       <= op_d;
         trk_vld_q  <= trk_vld_d;
         trk_own_q  <= trk_own_d;
         trk_tag_q  <= trk_tag_d;
      end
   end

   assign dp_valid   = dp_valid_q;
   assign dp_exp1    = op_q.exp1;
   assign dp_mant1   = op_q.mant1;
   assign dp_sign1   = op_q.sign1;
   assign dp_num2    = op_q.num2;
   assign dp_add_sub = op_q.add_sub;
   assign dp_nan1    = op_q.nan1;
   assign dp_zero1   = op_q.zero1;

   // A flush kills the response landing in the same cycle.
   assign rsp_fire   = trk_vld_q[LAT-1] & ~flush;
   assign rsp0_valid = rsp_fire & ~trk_own_q[LAT-1];
   assign rsp1_valid = rsp_fire & trk_own_q[LAT-1];
   assign rsp_tag    = rsp_fire ? trk_tag_q[LAT-1] : '0;
   assign rsp_data   = dp_res_data;
   assign busy       = dp_valid_q | (|trk_vld_q);

endmodule
